// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the bus hold arbiter and its round-robin selector.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        GRANT,
        RELEASE
    } arb_state_e;

    // Counters must hold the larger of the grant limit and the ack timeout.
    function automatic int cnt_width(input int max_grant, input int ack_timeout);
        int m;
        m = (max_grant > ack_timeout) ? max_grant : ack_timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bus_hold_arbiter_if.sv
// Arbiter-side bus signals: CPU cycle/strobe inputs, requester handshake and hold outputs.
interface bus_hold_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic               ALE;
    logic               RD_N;
    logic               WR_N;
    logic               cpu_hlda;
    logic [NUM_REQ-1:0] req;
    logic               HOLD;
    logic               HLDA;
    logic [NUM_REQ-1:0] grant;
    logic               timeout_err;

    modport master (
        output ALE, RD_N, WR_N, cpu_hlda, req,
        input  HOLD, HLDA, grant, timeout_err
    );

    modport slave (
        input  ALE, RD_N, WR_N, cpu_hlda, req,
        output HOLD, HLDA, grant, timeout_err
    );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request strictly after rr_last, wrapping at NUM_REQ.
module rr_priority_select #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_last,
    output logic [IW-1:0]      winner,
    output logic               valid
);
    logic [IW:0]        sum  [NUM_REQ];
    logic [IW-1:0]      cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[gi] is the requester gi+1 places after rr_last; sum < 2*NUM_REQ so one wrap suffices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, rr_last} + (IW + 1)'(gi + 1);
        assign cand[gi] = (sum[gi] >= (IW + 1)'(NUM_REQ)) ? IW'(sum[gi] - (IW + 1)'(NUM_REQ))
                                                          : sum[gi][IW-1:0];
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_hold_arbiter.sv
// Shares the 8088 system bus with NUM_REQ secondary masters via HOLD/HLDA, round-robin,
// with grant length limit, acknowledge timeout and an idle gap between grants.
module bus_hold_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_GRANT   = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_CYCLES  = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_clock_posedge,
    input  logic cpu_clock_negedge,
    bus_hold_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = cnt_width(MAX_GRANT, ACK_TIMEOUT);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GRANT_MAX = CW'(MAX_GRANT);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

    arb_state_e         state_q, state_d;
    logic               hold_q, hold_d;
    logic               hlda_q, hlda_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               timeout_q, timeout_d;
    logic [CW-1:0]      ack_cnt_q, ack_cnt_d;
    logic [CW-1:0]      grant_cnt_q, grant_cnt_d;
    logic [CW-1:0]      grant_cnt_inc;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]      rr_last_q, rr_last_d;
    logic               cyc_active_q, cyc_active_d;
    logic               strobe_seen_q, strobe_seen_d;
    logic [IW-1:0]      winner_idx;
    logic               winner_valid;
    logic               others_req;

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req     (bus.req),
        .rr_last (rr_last_q),
        .winner  (winner_idx),
        .valid   (winner_valid)
    );

    // While granted, rr_last_q holds the owner index, so grant_q masks the owner out.
    assign others_req = |(bus.req & ~grant_q);

    // CPU bus cycle tracker: open on ALE, close once a strobe has come and gone.
    always_comb begin
        cyc_active_d  = cyc_active_q;
        strobe_seen_d = strobe_seen_q;
        if (cyc_active_q && (!bus.RD_N || !bus.WR_N)) begin
            strobe_seen_d = 1'b1;
        end
        if (cpu_clock_negedge && cyc_active_q && strobe_seen_q && bus.RD_N && bus.WR_N) begin
            cyc_active_d  = 1'b0;
            strobe_seen_d = 1'b0;
        end
        if (cpu_clock_posedge && bus.ALE) begin
            cyc_active_d  = 1'b1;
            strobe_seen_d = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hlda_d        = hlda_q;
        grant_d       = grant_q;
        timeout_d     = 1'b0;
        ack_cnt_d     = ack_cnt_q;
        grant_cnt_d   = grant_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        rr_last_d     = rr_last_q;
        grant_cnt_inc = (grant_cnt_q == GRANT_MAX) ? grant_cnt_q : grant_cnt_q + 1'b1;

        if (cpu_clock_posedge && gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cpu_clock_posedge && |bus.req && gap_cnt_q == '0) begin
                    hold_d    = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (cpu_clock_posedge) begin
                    if (bus.cpu_hlda && !cyc_active_q && winner_valid) begin
                        grant_d             = '0;
                        grant_d[winner_idx] = 1'b1;
                        hlda_d              = 1'b1;
                        rr_last_d           = winner_idx;
                        grant_cnt_d         = '0;
                        state_d             = GRANT;
                    end else if (!(|bus.req)) begin
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        hold_d    = 1'b0;
                        timeout_d = 1'b1;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = IDLE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            GRANT: begin
                // The limit counts the clock being ended now, so a grant lasts MAX_GRANT clocks.
                if (cpu_clock_posedge) begin
                    grant_cnt_d = grant_cnt_inc;
                    if (!bus.req[rr_last_q] || (grant_cnt_inc == GRANT_MAX && others_req)) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (cpu_clock_negedge && hlda_q) begin
                    grant_d = '0;
                    hlda_d  = 1'b0;
                end else if (cpu_clock_posedge && !hlda_q) begin
                    hold_d    = 1'b0;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_q        <= 1'b0;
            hlda_q        <= 1'b0;
            grant_q       <= '0;
            timeout_q     <= 1'b0;
            ack_cnt_q     <= '0;
            grant_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            rr_last_q     <= IW'(NUM_REQ - 1);
            cyc_active_q  <= 1'b0;
            strobe_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hlda_q        <= hlda_d;
            grant_q       <= grant_d;
            timeout_q     <= timeout_d;
            ack_cnt_q     <= ack_cnt_d;
            grant_cnt_q   <= grant_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            rr_last_q     <= rr_last_d;
            cyc_active_q  <= cyc_active_d;
            strobe_seen_q <= strobe_seen_d;
        end
    end

    assign bus.HOLD        = hold_q;
    assign bus.HLDA        = hlda_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Scoreboard bench: each output transition is queued with the CPU-posedge count where it must appear.
module tb_bus_hold_arbiter;
    localparam int NUM_REQ = 2;

    logic clock = 1'b0;
    logic reset;
    logic cpu_clock_posedge;
    logic cpu_clock_negedge;

    bus_hold_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    bus_hold_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MAX_GRANT   (16),
        .ACK_TIMEOUT (64),
        .GAP_CYCLES  (1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_clock_posedge (cpu_clock_posedge),
        .cpu_clock_negedge (cpu_clock_negedge),
        .bus               (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        int         at;
        logic [4:0] out;   // {timeout_err, HOLD, HLDA, grant}
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         pcnt  = 0;
    bit         mon_en = 1'b0;
    bit         inv_ok = 1'b1;
    logic [4:0] prev_out = '0;
    logic [1:0] prev_grant = '0;
    logic [4:0] cur_out;
    ev_t        cur_ev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input string tag, input int at, input logic hold, input logic hlda,
                             input logic [1:0] grant, input logic to);
        ev_t e;
        e.tag = tag;
        e.at  = at;
        e.out = {to, hold, hlda, grant};
        exp_q.push_back(e);
    endtask

    task automatic wait_pe(input int n);
        int p0;
        repeat (n) begin
            p0 = pcnt;
            do @(negedge clock); while (pcnt == p0);
        end
    endtask

    // CPU clock = 4 system clocks; enables change on the falling system edge.
    initial begin
        int ph;
        ph = 0;
        cpu_clock_posedge = 1'b0;
        cpu_clock_negedge = 1'b0;
        forever begin
            @(negedge clock);
            ph = (ph + 1) % 4;
            cpu_clock_posedge = (ph == 0);
            cpu_clock_negedge = (ph == 2);
        end
    end

    always @(posedge clock) begin
        if (cpu_clock_posedge) pcnt <= pcnt + 1;
    end

    always @(negedge clock) begin
        cur_out = {bus.timeout_err, bus.HOLD, bus.HLDA, bus.grant};
        if (mon_en) begin
            if ((bus.grant & (bus.grant - 2'd1)) != 2'b00) inv_ok = 1'b0;
            if (bus.HLDA && !(bus.HOLD && bus.grant != 2'b00)) inv_ok = 1'b0;
            if (prev_grant != 2'b00 && bus.grant != 2'b00 && bus.grant != prev_grant) inv_ok = 1'b0;
            if (cur_out[3:0] != prev_out[3:0] || cur_out[4]) begin
                if (exp_q.size() == 0) begin
                    $display("ev unexpected at=%0d out=%b", pcnt, cur_out);
                    check_eq("ev_queue", exp_q.size(), 1);
                end else begin
                    cur_ev = exp_q.pop_front();
                    $display("ev %-10s at=%0d out=%b", cur_ev.tag, pcnt, cur_out);
                    check_eq({cur_ev.tag, "_out"}, 32'(cur_out), 32'(cur_ev.out));
                    check_eq({cur_ev.tag, "_at"}, pcnt, cur_ev.at);
                    check_eq({cur_ev.tag, "_inv"}, 32'(inv_ok), 1);
                end
            end
        end
        prev_out   = cur_out;
        prev_grant = bus.grant;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        reset        = 1'b1;
        bus.ALE      = 1'b0;
        bus.RD_N     = 1'b1;
        bus.WR_N     = 1'b1;
        bus.cpu_hlda = 1'b0;
        bus.req      = '0;
        repeat (6) @(negedge clock);
        check_eq("rst_out", {27'b0, bus.timeout_err, bus.HOLD, bus.HLDA, bus.grant}, 0);
        mon_en = 1'b1;
        reset  = 1'b0;
        wait_pe(2);

        // 1: basic grant with late acknowledge, then release on req drop
        t = pcnt;
        bus.req = 2'b01;
        expect_ev("t1_hold",  t + 1, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t1_grant", t + 3, 1'b1, 1'b1, 2'b01, 1'b0);
        expect_ev("t1_drop",  t + 7, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t1_rel",   t + 8, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_pe(2); bus.cpu_hlda = 1'b1;
        wait_pe(4); bus.req = 2'b00;
        wait_pe(3); bus.cpu_hlda = 1'b0;
        wait_pe(2);

        // 2: grant deferred until the in-flight CPU read completes
        t = pcnt;
        bus.ALE = 1'b1; bus.req = 2'b01; bus.cpu_hlda = 1'b1;
        expect_ev("t2_hold",  t + 1, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t2_grant", t + 4, 1'b1, 1'b1, 2'b01, 1'b0);
        expect_ev("t2_drop",  t + 5, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t2_rel",   t + 6, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_pe(1); bus.ALE = 1'b0; bus.RD_N = 1'b0;
        wait_pe(2); bus.RD_N = 1'b1;
        wait_pe(1); bus.req = 2'b00;
        wait_pe(4);

        // 3: two constant requesters alternate at the grant limit
        reset = 1'b1;
        wait_pe(1); reset = 1'b0;
        wait_pe(1);
        t = pcnt;
        bus.req = 2'b11;
        expect_ev("t3_hold0",  t + 1,  1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_g01a",   t + 2,  1'b1, 1'b1, 2'b01, 1'b0);
        expect_ev("t3_drop0",  t + 18, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_rel0",   t + 19, 1'b0, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_hold1",  t + 21, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_g10",    t + 22, 1'b1, 1'b1, 2'b10, 1'b0);
        expect_ev("t3_drop1",  t + 38, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_rel1",   t + 39, 1'b0, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_hold2",  t + 41, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_g01b",   t + 42, 1'b1, 1'b1, 2'b01, 1'b0);
        expect_ev("t3_drop2",  t + 45, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t3_rel2",   t + 46, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_pe(44); bus.req = 2'b00;
        wait_pe(4);

        // 4: a sole requester keeps the bus past the grant limit
        t = pcnt;
        bus.req = 2'b10;
        expect_ev("t4_hold",  t + 1,  1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t4_grant", t + 2,  1'b1, 1'b1, 2'b10, 1'b0);
        expect_ev("t4_drop",  t + 43, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t4_rel",   t + 44, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_pe(42); bus.req = 2'b00;
        wait_pe(4);

        // 5: no acknowledge -> timeout pulse, gap, HOLD again
        bus.cpu_hlda = 1'b0;
        t = pcnt;
        bus.req = 2'b01;
        expect_ev("t5_hold",  t + 1,  1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t5_tmo",   t + 65, 1'b0, 1'b0, 2'b00, 1'b1);
        expect_ev("t5_hold2", t + 67, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t5_grant", t + 68, 1'b1, 1'b1, 2'b01, 1'b0);
        wait_pe(67); bus.cpu_hlda = 1'b1;

        // 6: reset during a grant clears everything on the next clock
        wait_pe(2);
        t = pcnt;
        reset = 1'b1; bus.req = 2'b11;
        expect_ev("t6_rst",   t,     1'b0, 1'b0, 2'b00, 1'b0);
        expect_ev("t6_hold",  t + 3, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t6_grant", t + 4, 1'b1, 1'b1, 2'b01, 1'b0);
        expect_ev("t6_drop",  t + 6, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_ev("t6_rel",   t + 7, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_pe(2); reset = 1'b0;
        wait_pe(3); bus.req = 2'b00;
        wait_pe(4);

        check_eq("ev_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
